// File: rtl/adder_ctrl_pkg.sv
// Shared types, constants and the byte-slice helper for the shared-adder controller.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned ADD_LAT = 1;
    // Widest vector byte_slice accepts; callers zero-extend into it.
    localparam int unsigned SLICE_W = 1024;

    function automatic logic [7:0] byte_slice(input logic [SLICE_W-1:0] v, input int unsigned idx);
        return 8'(v >> (8 * idx));
    endfunction

endpackage

// File: rtl/adder_share_ctrl_arb.sv
// Round-robin arbiter: search starts one past ptr and wraps; one-hot grant plus index.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic           w_found;
    logic [IDW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((32'(ptr) + k) % NREQ);
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/eight_bit_adder.sv
// Shared 8-bit adder: operands registered, carry-in and sum combinational.
module eight_bit_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] r_a;
    logic [7:0] r_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= a;
            r_b <= b;
        end
    end

    assign {cout, sum} = 9'(r_a) + 9'(r_b) + 9'(cin);

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one registered 8-bit adder among NREQ requesters, running each W-bit add
// LSB byte first with the carry chained through a register.
module adder_share_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NBYTES = 4,
    parameter int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*NBYTES*8-1:0] req_a,
    input  logic [NREQ*NBYTES*8-1:0] req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [NBYTES*8-1:0]      rsp_sum,
    output logic                     rsp_cout,
    output logic                     busy,
    output logic [7:0]               add_a,
    output logic [7:0]               add_b,
    output logic                     add_cin,
    input  logic [7:0]               add_sum,
    input  logic                     add_cout
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned JLAST = NBYTES - 1 + ADD_LAT;
    localparam int unsigned JW    = $clog2(JLAST + 1);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [JW-1:0]   r_j;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_cin;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_res;
    logic            r_carry;
    logic [7:0]      r_add_a;
    logic [7:0]      r_add_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_sum;
    logic            r_rsp_cout;
    logic            r_busy;

    logic            w_en;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_accept;
    logic [W-1:0]    w_a_sel;
    logic [W-1:0]    w_b_sel;
    logic [W-1:0]    w_res_next;

    // Grants only in IDLE and never while reset is held.
    assign w_en = (r_state == IDLE) && rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_ptr),
        .en     (w_en),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_accept   = |(req_valid & w_gnt);
    assign w_a_sel    = W'(req_a >> (32'(w_gnt_id) * W));
    assign w_b_sel    = W'(req_b >> (32'(w_gnt_id) * W));
    // Result bytes shift in from the top so byte 0 lands at the bottom after NBYTES sums.
    assign w_res_next = W'({add_sum, r_res} >> 8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_j         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_id        <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_a_sel;
                        r_b     <= w_b_sel;
                        r_cin   <= req_cin[w_gnt_id];
                        r_id    <= w_gnt_id;
                        r_ptr   <= w_gnt_id;
                        r_j     <= '0;
                        r_add_a <= byte_slice(SLICE_W'(w_a_sel), 0);
                        r_add_b <= byte_slice(SLICE_W'(w_b_sel), 0);
                        r_carry <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_j != '0) begin
                        r_res <= w_res_next;
                    end
                    if (32'(r_j) + 1 < NBYTES) begin
                        r_add_a <= byte_slice(SLICE_W'(r_a), 32'(r_j) + 1);
                        r_add_b <= byte_slice(SLICE_W'(r_b), 32'(r_j) + 1);
                    end else begin
                        r_add_a <= '0;
                        r_add_b <= '0;
                    end
                    if (r_j == JW'(JLAST)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_sum   <= w_res_next;
                        r_rsp_cout  <= add_cout;
                        r_carry     <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        // Carry for the byte the adder sums next cycle.
                        r_carry <= (r_j == '0) ? r_cin : add_cout;
                        r_j     <= r_j + JW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign busy      = r_busy;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_carry;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl with a real eight_bit_adder: directed cases plus a
// randomized run against a transaction-level reference model.
module tb_adder_share_ctrl;

    localparam int NREQ   = 4;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int IDW    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_cin;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_sum;
    logic                rsp_cout;
    logic                busy;
    logic [7:0]          add_a;
    logic [7:0]          add_b;
    logic                add_cin;
    logic [7:0]          add_sum;
    logic                add_cout;

    adder_share_ctrl #(.NREQ(NREQ), .NBYTES(NBYTES), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    eight_bit_adder u_add (
        .clk(clk), .rst(rst),
        .a(add_a), .b(add_b), .cin(add_cin),
        .sum(add_sum), .cout(add_cout)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic flag_timeout(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting at %0t", tag, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one transaction at a time, W+1-bit plain addition.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mph_t;
    mph_t            m_ph = M_IDLE;
    int              m_ptr = NREQ - 1;
    int              m_cnt = 0;
    int              m_id = 0;
    int              m_nrsp = 0;
    int              m_pick;
    logic [W:0]      m_res = '0;
    logic [NREQ-1:0] m_rdy;
    logic [NREQ-1:0] m_acc = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (v[IDW'(idx)]) return idx;
        end
        return -1;
    endfunction

    always_comb begin
        m_pick = rr_pick(req_valid, m_ptr);
        m_rdy  = '0;
        if (rst && m_ph == M_IDLE && m_pick >= 0) m_rdy[IDW'(m_pick)] = 1'b1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph  <= M_IDLE;
            m_ptr <= NREQ - 1;
            m_cnt <= 0;
            m_acc <= '0;
        end else begin
            m_acc <= '0;
            case (m_ph)
                M_IDLE: if (m_pick >= 0) begin
                    m_acc <= m_rdy;
                    m_id  <= m_pick;
                    m_ptr <= m_pick;
                    m_res <= (W+1)'(W'(req_a >> (m_pick * W))) + (W+1)'(W'(req_b >> (m_pick * W)))
                           + (W+1)'(req_cin[IDW'(m_pick)]);
                    m_cnt <= 0;
                    m_ph  <= M_RUN;
                end
                M_RUN: begin
                    if (m_cnt == NBYTES) m_ph <= M_DONE;
                    else m_cnt <= m_cnt + 1;
                end
                default: if (rsp_ready) begin
                    m_ph   <= M_IDLE;
                    m_nrsp <= m_nrsp + 1;
                end
            endcase
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("req_ready", 64'(req_ready), 64'(m_rdy));
        check("busy", 64'(busy), 64'(rst && m_ph != M_IDLE));
        check("rsp_valid", 64'(rsp_valid), 64'(m_ph == M_DONE));
        if (m_ph == M_DONE) begin
            check("rsp_id", 64'(rsp_id), 64'(m_id));
            check("rsp_sum", 64'(rsp_sum), 64'(m_res[W-1:0]));
            check("rsp_cout", 64'(rsp_cout), 64'(m_res[W]));
        end
    end

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return 32'h00FF_00FF;
            default: return W'($urandom());
        endcase
    endfunction

    bit rand_mode = 1'b0;
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            req_valid = NREQ'($urandom());
            req_a     = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
            req_b     = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
            req_cin   = NREQ'($urandom());
            rsp_ready = ($urandom_range(0, 99) < 60);
        end
    end

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        req_a   = (req_a & ~({{(NREQ*W-W){1'b0}}, {W{1'b1}}} << (id * W))) | ((NREQ*W)'(a) << (id * W));
        req_b   = (req_b & ~({{(NREQ*W-W){1'b0}}, {W{1'b1}}} << (id * W))) | ((NREQ*W)'(b) << (id * W));
        req_cin[IDW'(id)]   = cin;
        req_valid[IDW'(id)] = 1'b1;
    endtask

    task automatic wait_accept(input int id, input string tag);
        int n = 0;
        while (n < 30) begin
            tick();
            if (m_acc[IDW'(id)]) break;
            n++;
        end
        if (n >= 30) flag_timeout(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || rsp_valid) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) flag_timeout(tag);
    endtask

    initial begin
        #900_000;
        flag_timeout("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        int base;
        int n;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        // Reset state, including no grant to a pending request
        req_valid = '1;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_add_a", 64'(add_a), 64'(0));
        check("rst_add_b", 64'(add_b), 64'(0));
        check("rst_add_cin", 64'(add_cin), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, busy}), 64'(0));
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();

        // Carry ripples through every byte
        rsp_ready = 1'b1;
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_accept(0, "t1_accept");
        req_valid = '0;
        repeat (4) tick();
        check("t1_early", 64'(rsp_valid), 64'(0));
        tick();
        check("t1_valid", 64'(rsp_valid), 64'(1));
        check("t1_sum", 64'(rsp_sum), 64'(0));
        check("t1_cout", 64'(rsp_cout), 64'(1));
        check("t1_id", 64'(rsp_id), 64'(0));
        wait_idle("t1_idle");

        // Carry-in enters byte 0 and chains
        set_op(1, 32'h00FF_00FF, 32'h0000_0000, 1'b1);
        wait_accept(1, "t2_accept");
        req_valid = '0;
        repeat (5) tick();
        check("t2_sum", 64'(rsp_sum), 64'(32'h00FF_0100));
        check("t2_cout", 64'(rsp_cout), 64'(0));
        check("t2_id", 64'(rsp_id), 64'(1));
        wait_idle("t2_idle");

        // Backpressure: response held, no grants, regrant one cycle after release
        rsp_ready = 1'b0;
        set_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        wait_accept(0, "t4_accept");
        req_valid = '0;
        set_op(1, 32'h0000_0010, 32'h0000_0020, 1'b0);
        set_op(2, 32'h0000_0030, 32'h0000_0040, 1'b0);
        repeat (5) tick();
        for (int k = 0; k < 10; k++) begin
            check("t4_hold_valid", 64'(rsp_valid), 64'(1));
            check("t4_hold_sum", 64'(rsp_sum), 64'(32'h2345_678A));
            check("t4_hold_rdy", 64'(req_ready), 64'(0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t4_regrant", 64'(req_ready), 64'(4'b0010));
        tick();
        check("t4_busy", 64'(busy), 64'(1));
        req_valid = '0;
        wait_idle("t4_idle");

        // Reset mid-run discards the op and restores the pointer
        set_op(2, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
        wait_accept(2, "t5_accept");
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_valid", 64'(rsp_valid), 64'(0));
        check("t5_add_a", 64'(add_a), 64'(0));
        req_valid = '1;
        tick();
        tick();
        check("t5_rdy_in_rst", 64'(req_ready), 64'(0));
        rst = 1'b1;
        #1;
        check("t5_first_grant", 64'(req_ready), 64'(4'b0001));

        // All requesters continuously pending: strict rotation
        for (int r = 0; r < 5; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 20);
            if (n >= 20) flag_timeout("t3_rsp");
            else check("t3_id", 64'(rsp_id), 64'(exp_ids[r]));
        end
        tick();
        req_valid = '0;
        wait_idle("t3_idle");

        // Random traffic with consumer stalls
        base = m_nrsp;
        rand_mode = 1'b1;
        n = 0;
        while (m_nrsp < base + 1000 && n < 40000) begin
            tick();
            n++;
        end
        if (n >= 40000) flag_timeout("rand_ops");
        rand_mode = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
